// File: rtl/interrupt_moderator_if.sv
// Handshake bundle between the packet/interrupt logic and the coalescing stage.
interface interrupt_moderator_if;
    logic pkt_event;
    logic int_issued;
    logic send_interrupt;

    // Upstream side: reports packets and interrupt acceptance, watches the request.
    modport master (
        output pkt_event,
        output int_issued,
        input  send_interrupt
    );

    // Coalescing stage side.
    modport slave (
        input  pkt_event,
        input  int_issued,
        output send_interrupt
    );
endinterface

// File: rtl/interrupt_moderator.sv
// Interrupt coalescing stage: counts delivered packets and raises one held
// interrupt request when a packet threshold or a microsecond timeout is reached.
module interrupt_moderator #(
    parameter int CNT_W    = 16,
    parameter int TMR_W    = 20,
    parameter int PRESCALE = 250
) (
    input  logic                 trn_clk,
    input  logic                 trn_reset_n,
    interrupt_moderator_if.slave irq_bus,
    input  logic                 mod_enable,
    input  logic [CNT_W-1:0]     pkt_thresh,
    input  logic [TMR_W-1:0]     timeout_us,
    output logic [CNT_W-1:0]     pending_cnt,
    output logic [31:0]          irq_count
);

    localparam int PS_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRE  = 2'd2
    } state_t;

    state_t           state;
    logic [PS_W-1:0]  presc;
    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] new_cnt;
    logic             send_q;

    logic [CNT_W-1:0] eff_thresh;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] new_inc;
    logic [CNT_W-1:0] new_next;
    logic [TMR_W-1:0] timer_next;
    logic             tick;
    logic             thresh_hit;
    logic             timeout_hit;

    assign irq_bus.send_interrupt = send_q;

    // Next-value helpers: saturating counters, prescaler tick and fire conditions.
    always_comb begin
        eff_thresh  = (pkt_thresh == '0) ? CNT_W'(1) : pkt_thresh;
        cnt_inc     = (pending_cnt == '1) ? pending_cnt : pending_cnt + CNT_W'(1);
        cnt_next    = irq_bus.pkt_event ? cnt_inc : pending_cnt;
        new_inc     = (new_cnt == '1) ? new_cnt : new_cnt + CNT_W'(1);
        new_next    = irq_bus.pkt_event ? new_inc : new_cnt;
        tick        = (presc == PS_W'(PRESCALE - 1));
        timer_next  = (tick && (timer != '1)) ? timer + TMR_W'(1) : timer;
        thresh_hit  = (cnt_next >= eff_thresh);
        timeout_hit = tick && (timeout_us != '0) && (timer_next == timeout_us);
    end

    // Coalescing FSM with registered request, counters and timer.
    always_ff @(posedge trn_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            state       <= IDLE;
            send_q      <= 1'b0;
            pending_cnt <= '0;
            irq_count   <= '0;
            new_cnt     <= '0;
            presc       <= '0;
            timer       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    send_q <= 1'b0;
                    if (irq_bus.pkt_event) begin
                        pending_cnt <= CNT_W'(1);
                        new_cnt     <= '0;
                        presc       <= '0;
                        timer       <= '0;
                        if (!mod_enable || (eff_thresh == CNT_W'(1))) begin
                            state  <= FIRE;
                            send_q <= 1'b1;
                        end else begin
                            state <= ARMED;
                        end
                    end
                end

                ARMED: begin
                    pending_cnt <= cnt_next;
                    presc       <= tick ? '0 : presc + PS_W'(1);
                    timer       <= timer_next;
                    if (thresh_hit || timeout_hit || (!mod_enable && (cnt_next != '0))) begin
                        state   <= FIRE;
                        send_q  <= 1'b1;
                        new_cnt <= '0;
                    end
                end

                FIRE: begin
                    if (irq_bus.int_issued) begin
                        send_q    <= 1'b0;
                        irq_count <= irq_count + 32'd1;
                        new_cnt   <= '0;
                        if (new_next != '0) begin
                            pending_cnt <= new_next;
                            presc       <= '0;
                            timer       <= '0;
                            state       <= ARMED;
                        end else begin
                            pending_cnt <= '0;
                            state       <= IDLE;
                        end
                    end else begin
                        send_q      <= 1'b1;
                        new_cnt     <= new_next;
                        pending_cnt <= cnt_next;
                    end
                end

                default: begin
                    state  <= IDLE;
                    send_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_moderator.sv
// Directed self-checking bench for interrupt_moderator (small counters, fast prescaler).
module tb_interrupt_moderator;

    localparam int CNT_W    = 4;
    localparam int TMR_W    = 8;
    localparam int PRESCALE = 4;

    logic             trn_clk;
    logic             trn_reset_n;
    logic             mod_enable;
    logic [CNT_W-1:0] pkt_thresh;
    logic [TMR_W-1:0] timeout_us;
    logic [CNT_W-1:0] pending_cnt;
    logic [31:0]      irq_count;

    int assert_count = 0;
    int fail_count   = 0;
    int latency;

    interrupt_moderator_if irq_bus ();

    interrupt_moderator #(
        .CNT_W    (CNT_W),
        .TMR_W    (TMR_W),
        .PRESCALE (PRESCALE)
    ) dut (
        .trn_clk     (trn_clk),
        .trn_reset_n (trn_reset_n),
        .irq_bus     (irq_bus),
        .mod_enable  (mod_enable),
        .pkt_thresh  (pkt_thresh),
        .timeout_us  (timeout_us),
        .pending_cnt (pending_cnt),
        .irq_count   (irq_count)
    );

    // Free-running 100 MHz-style clock.
    initial begin
        trn_clk = 1'b0;
        forever #5 trn_clk = ~trn_clk;
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Counts one comparison and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drives one cycle of handshake inputs, then samples point is 1 ns after that edge.
    task automatic applyStimulus(input logic ev, input logic iss);
        irq_bus.pkt_event  = ev;
        irq_bus.int_issued = iss;
        @(posedge trn_clk);
        #1;
        irq_bus.pkt_event  = 1'b0;
        irq_bus.int_issued = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge trn_clk);
            #1;
        end
    endtask

    task automatic doReset();
        #2;
        trn_reset_n = 1'b0;
        #10;
        trn_reset_n = 1'b1;
        @(posedge trn_clk);
        #1;
    endtask

    initial begin
        trn_reset_n        = 1'b0;
        irq_bus.pkt_event  = 1'b0;
        irq_bus.int_issued = 1'b0;
        mod_enable         = 1'b1;
        pkt_thresh         = 4'd3;
        timeout_us         = 8'd0;
        #22;
        trn_reset_n = 1'b1;
        @(posedge trn_clk);
        #1;

        checkOutput("reset_send", 32'(irq_bus.send_interrupt), 32'd0);
        checkOutput("reset_pending", 32'(pending_cnt), 32'd0);
        checkOutput("reset_irq", irq_count, 32'd0);

        // 1: threshold of 3 packets
        applyStimulus(1'b1, 1'b0);
        idleCycles(1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("t1_send_after2", 32'(irq_bus.send_interrupt), 32'd0);
        checkOutput("t1_pending_after2", 32'(pending_cnt), 32'd2);
        applyStimulus(1'b1, 1'b0);
        checkOutput("t1_send_after3", 32'(irq_bus.send_interrupt), 32'd1);
        checkOutput("t1_pending_after3", 32'(pending_cnt), 32'd3);
        idleCycles(2);
        checkOutput("t1_send_held", 32'(irq_bus.send_interrupt), 32'd1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t1_send_cleared", 32'(irq_bus.send_interrupt), 32'd0);
        checkOutput("t1_pending_cleared", 32'(pending_cnt), 32'd0);
        checkOutput("t1_irq", irq_count, 32'd1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t1_issued_in_idle_ignored", irq_count, 32'd1);
        checkOutput("t1_idle_send", 32'(irq_bus.send_interrupt), 32'd0);

        // 2: timeout of 5 ticks at 4 cycles per tick
        pkt_thresh = 4'd15;
        timeout_us = 8'd5;
        applyStimulus(1'b1, 1'b0);
        latency = 0;
        while (!irq_bus.send_interrupt && latency < 40) begin
            idleCycles(1);
            latency++;
        end
        checkOutput("t2_timeout_latency", 32'(latency), 32'd20);
        checkOutput("t2_send", 32'(irq_bus.send_interrupt), 32'd1);
        checkOutput("t2_pending", 32'(pending_cnt), 32'd1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t2_irq", irq_count, 32'd2);
        checkOutput("t2_pending_cleared", 32'(pending_cnt), 32'd0);

        // 3: coalescing disabled, request held while the controller stalls
        timeout_us = 8'd0;
        mod_enable = 1'b0;
        applyStimulus(1'b1, 1'b0);
        checkOutput("t3_send_first", 32'(irq_bus.send_interrupt), 32'd1);
        checkOutput("t3_pending_first", 32'(pending_cnt), 32'd1);
        idleCycles(2);
        applyStimulus(1'b1, 1'b0);
        checkOutput("t3_pending_second", 32'(pending_cnt), 32'd2);
        idleCycles(5);
        checkOutput("t3_send_held", 32'(irq_bus.send_interrupt), 32'd1);
        mod_enable = 1'b1;
        applyStimulus(1'b0, 1'b1);
        checkOutput("t3_send_dropped", 32'(irq_bus.send_interrupt), 32'd0);
        checkOutput("t3_pending_carry", 32'(pending_cnt), 32'd1);
        checkOutput("t3_irq", irq_count, 32'd3);
        idleCycles(3);
        checkOutput("t3_armed_send", 32'(irq_bus.send_interrupt), 32'd0);
        checkOutput("t3_armed_pending", 32'(pending_cnt), 32'd1);
        pkt_thresh = 4'd1;
        idleCycles(1);
        checkOutput("t3_thresh_lowered_fire", 32'(irq_bus.send_interrupt), 32'd1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t3_irq_second", irq_count, 32'd4);
        checkOutput("t3_pending_idle", 32'(pending_cnt), 32'd0);
        pkt_thresh = 4'd15;
        applyStimulus(1'b1, 1'b0);
        checkOutput("t3_armed_again", 32'(irq_bus.send_interrupt), 32'd0);
        mod_enable = 1'b0;
        idleCycles(1);
        checkOutput("t3_disable_in_armed_fire", 32'(irq_bus.send_interrupt), 32'd1);
        mod_enable = 1'b1;
        applyStimulus(1'b0, 1'b1);
        checkOutput("t3_irq_third", irq_count, 32'd5);

        // 4: event coincident with acceptance
        doReset();
        pkt_thresh = 4'd1;
        applyStimulus(1'b1, 1'b0);
        checkOutput("t4_send_fire", 32'(irq_bus.send_interrupt), 32'd1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("t4_send_gap", 32'(irq_bus.send_interrupt), 32'd0);
        checkOutput("t4_pending", 32'(pending_cnt), 32'd1);
        checkOutput("t4_irq", irq_count, 32'd1);
        idleCycles(1);
        checkOutput("t4_send_refire", 32'(irq_bus.send_interrupt), 32'd1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t4_irq_second", irq_count, 32'd2);
        checkOutput("t4_pending_idle", 32'(pending_cnt), 32'd0);

        // 5: pending count saturation while the request is held
        pkt_thresh = 4'd0;
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("t5_pending_saturated", 32'(pending_cnt), 32'd15);
        checkOutput("t5_send", 32'(irq_bus.send_interrupt), 32'd1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t5_pending_carry_sat", 32'(pending_cnt), 32'd15);
        checkOutput("t5_irq", irq_count, 32'd3);
        idleCycles(1);
        checkOutput("t5_refire", 32'(irq_bus.send_interrupt), 32'd1);

        // 6: asynchronous reset in the middle of a held request
        #3;
        trn_reset_n = 1'b0;
        #1;
        checkOutput("t6_async_send", 32'(irq_bus.send_interrupt), 32'd0);
        checkOutput("t6_async_pending", 32'(pending_cnt), 32'd0);
        checkOutput("t6_async_irq", irq_count, 32'd0);
        #10;
        trn_reset_n = 1'b1;
        @(posedge trn_clk);
        #1;
        pkt_thresh = 4'd3;
        applyStimulus(1'b1, 1'b0);
        checkOutput("t6_post_pending", 32'(pending_cnt), 32'd1);
        checkOutput("t6_post_send", 32'(irq_bus.send_interrupt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
